// File: rtl/sha512_pkg.sv
// Shared constants and types for the SHA-512 message padder.
package sha512_pkg;

   localparam int CHUNK_BITS      = 1024;
   localparam int WORD_BITS       = 64;
   localparam int WORDS_PER_CHUNK = 16;
   localparam int LEN_FIELD_BYTES = 16;
   localparam logic [7:0] PAD_BYTE = 8'h80;

   // FILL collects words, EMIT offers a data chunk, PAD builds the trailing
   // length-only chunk, EMIT_PAD offers that trailing chunk.
   typedef enum logic [1:0] {
      FILL     = 2'd0,
      EMIT     = 2'd1,
      PAD      = 2'd2,
      EMIT_PAD = 2'd3
   } pad_state_e;

   // Word 0 sits in the most significant 64 bits of the flattened chunk.
   typedef logic [0:15][63:0] chunk_words_t;

endpackage

// File: rtl/sha512_pad_if.sv
// Byte-stream input and chunk output bundle of the SHA-512 padder.
// master: message source / chunk consumer side; slave: the padder.
interface sha512_pad_if;

   logic [63:0]                      in_data;
   logic [3:0]                       in_bytes;
   logic                             in_last;
   logic                             in_valid;
   logic                             in_ready;
   logic [sha512_pkg::CHUNK_BITS-1:0] chunk;
   logic                             chunk_first;
   logic                             chunk_last;
   logic                             chunk_valid;
   logic                             chunk_ready;
   logic                             err;

   modport master (
      output in_data, in_bytes, in_last, in_valid, chunk_ready,
      input  in_ready, chunk, chunk_first, chunk_last, chunk_valid, err
   );

   modport slave (
      input  in_data, in_bytes, in_last, in_valid, chunk_ready,
      output in_ready, chunk, chunk_first, chunk_last, chunk_valid, err
   );

endinterface

// File: rtl/sha512_pad_word.sv
// Keeps the left nbytes_i bytes of a word, drops the rest, and optionally
// drops the 0x80 pad marker into the first unused byte position.
module sha512_pad_word
   import sha512_pkg::*;
(
   input  logic [63:0] word_i,
   input  logic [3:0]  nbytes_i,
   input  logic        insert_i,
   output logic [63:0] word_o
);

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_byte
         assign word_o[63-8*gi -: 8] =
            (nbytes_i > 4'(gi))                 ? word_i[63-8*gi -: 8] :
            (insert_i && (nbytes_i == 4'(gi)))  ? PAD_BYTE             :
                                                  8'h00;
      end
   endgenerate

endmodule

// File: rtl/sha512_pad.sv
// SHA-512 message padder: packs 64-bit big-endian words into 1024-bit chunks,
// appends 0x80, zero fill and the 128-bit bit length, and flags first/last
// chunk of each message. Optional input checking with sticky err is built
// when SHA512_PAD_ERR_CHECK_EN is defined; otherwise err is tied low.
module sha512_pad
   import sha512_pkg::*;
#(
   parameter int LEN_W = 64
) (
   input  logic         clk,
   input  logic         reset,
   sha512_pad_if.slave  bus
);

   pad_state_e       state_q, state_d;
   chunk_words_t     buf_q, buf_d;
   logic [3:0]       idx_q, idx_d;
   logic [LEN_W-1:0] count_q, count_d;
   logic             first_q, first_d;
   logic             last_q, last_d;
   logic             pend80_q, pend80_d;
   logic             need_pad_q, need_pad_d;
   logic             ready_q;

   logic             fire;
   logic             emitting;
   logic [3:0]       bytes_eff;
   logic [LEN_W-1:0] count_next;
   logic [LEN_W-1:0] len_cnt;
   logic [127:0]     len_bits;
   logic [7:0]       pos;
   logic [63:0]      word_out;

`ifdef SHA512_PAD_ERR_CHECK_EN
   // Out-of-range or short non-final words are accepted as full words.
   assign bytes_eff = (!bus.in_last || (bus.in_bytes > 4'd8)) ? 4'd8 : bus.in_bytes;
`else
   assign bytes_eff = bus.in_bytes;
`endif

   assign fire       = bus.in_valid && ready_q && (state_q == FILL);
   assign emitting   = (state_q == EMIT) || (state_q == EMIT_PAD);
   assign count_next = count_q + LEN_W'(bytes_eff);
   assign pos        = {1'b0, idx_q, 3'b000} + {4'b0000, bytes_eff};
   // The PAD chunk reports the stored total; the FILL path the running total.
   assign len_cnt    = (state_q == PAD) ? count_q : count_next;
   assign len_bits   = 128'({len_cnt, 3'b000});

   // One masking unit serves both the incoming word and the PAD chunk word 0.
   sha512_pad_word u_word (
      .word_i   ((state_q == PAD) ? 64'h0 : bus.in_data),
      .nbytes_i ((state_q == PAD) ? 4'd0  : bytes_eff),
      .insert_i ((state_q == PAD) ? pend80_q : bus.in_last),
      .word_o   (word_out)
   );

   // Next-state and buffer update for fill, emit and pad phases.
   always_comb begin
      state_d    = state_q;
      buf_d      = buf_q;
      idx_d      = idx_q;
      count_d    = count_q;
      first_d    = first_q;
      last_d     = last_q;
      pend80_d   = pend80_q;
      need_pad_d = need_pad_q;
      case (state_q)
         FILL: begin
            if (fire) begin
               buf_d[idx_q] = word_out;
               idx_d        = idx_q + 4'd1;
               count_d      = count_next;
               if (bus.in_last) begin
                  // A full final word pushes the marker into the next word.
                  if ((bytes_eff == 4'd8) && (idx_q != 4'd15))
                     buf_d[idx_q + 4'd1] = {PAD_BYTE, 56'h0};
                  idx_d   = 4'd0;
                  state_d = EMIT;
                  if (pos <= 8'd111) begin
                     buf_d[14]  = len_bits[127:64];
                     buf_d[15]  = len_bits[63:0];
                     last_d     = 1'b1;
                     need_pad_d = 1'b0;
                  end else begin
                     last_d     = 1'b0;
                     need_pad_d = 1'b1;
                     pend80_d   = (pos == 8'd128);
                  end
               end else if (idx_q == 4'd15) begin
                  last_d     = 1'b0;
                  need_pad_d = 1'b0;
                  state_d    = EMIT;
               end
            end
         end
         EMIT: begin
            if (bus.chunk_ready) begin
               buf_d   = '0;
               first_d = 1'b0;
               idx_d   = 4'd0;
               if (last_q) begin
                  first_d = 1'b1;
                  count_d = '0;
                  last_d  = 1'b0;
                  state_d = FILL;
               end else if (need_pad_q) begin
                  state_d = PAD;
               end else begin
                  state_d = FILL;
               end
            end
         end
         PAD: begin
            buf_d      = '0;
            buf_d[0]   = word_out;
            buf_d[14]  = len_bits[127:64];
            buf_d[15]  = len_bits[63:0];
            last_d     = 1'b1;
            pend80_d   = 1'b0;
            need_pad_d = 1'b0;
            state_d    = EMIT_PAD;
         end
         EMIT_PAD: begin
            if (bus.chunk_ready) begin
               buf_d   = '0;
               first_d = 1'b1;
               count_d = '0;
               idx_d   = 4'd0;
               last_d  = 1'b0;
               state_d = FILL;
            end
         end
         default: state_d = FILL;
      endcase
   end

   // State and datapath registers; reset discards any partial message.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= FILL;
         buf_q      <= '0;
         idx_q      <= '0;
         count_q    <= '0;
         first_q    <= 1'b1;
         last_q     <= 1'b0;
         pend80_q   <= 1'b0;
         need_pad_q <= 1'b0;
         ready_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         buf_q      <= buf_d;
         idx_q      <= idx_d;
         count_q    <= count_d;
         first_q    <= first_d;
         last_q     <= last_d;
         pend80_q   <= pend80_d;
         need_pad_q <= need_pad_d;
         ready_q    <= (state_d == FILL);
      end
   end

`ifdef SHA512_PAD_ERR_CHECK_EN
   logic err_q;
   logic err_set;
   assign err_set = (bus.in_bytes > 4'd8) ||
                    (!bus.in_last && (bus.in_bytes != 4'd8)) ||
                    (count_next < count_q);

   // Sticky protocol error flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         err_q <= 1'b0;
      else if (fire && err_set)
         err_q <= 1'b1;
   end
   assign bus.err = err_q;
`else
   assign bus.err = 1'b0;
`endif

   assign bus.in_ready    = ready_q;
   assign bus.chunk       = buf_q;
   assign bus.chunk_valid = emitting;
   assign bus.chunk_first = emitting && first_q;
   assign bus.chunk_last  = emitting && last_q;

endmodule

// File: tb/tb_sha512_pad.sv
// Scoreboard bench for sha512_pad: stimulus pushes expected chunks, a monitor
// pops and compares each chunk as it is accepted. With SHA512_PAD_ERR_CHECK_EN
// defined it also exercises the sticky err flag.
module tb_sha512_pad;
   import sha512_pkg::*;

   typedef struct {
      logic [1023:0] data;
      logic          first;
      logic          last;
      string         name;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   sha512_pad_if bus_if ();

   sha512_pad #(.LEN_W(64)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   int   checks   = 0;
   int   failures = 0;
   exp_t exp_q[$];
   exp_t mon_e;
   chunk_words_t w;
   chunk_words_t abc_w;

   task automatic chk1(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic chk_chunk(input string name, input logic [1023:0] act, input logic [1023:0] req);
      int k;
      checks++;
      if (act !== req) begin
         failures++;
         k = 0;
         while (k < 15 && act[1023-64*k -: 64] === req[1023-64*k -: 64]) k++;
         $display("FAIL %s_chunk word%0d actual=%h required=%h",
                  name, k, act[1023-64*k -: 64], req[1023-64*k -: 64]);
      end
   endtask

   task automatic expect_chunk(input chunk_words_t cw, input logic f, input logic l, input string name);
      exp_t e;
      e.data  = cw;
      e.first = f;
      e.last  = l;
      e.name  = name;
      exp_q.push_back(e);
   endtask

   function automatic logic [63:0] dw(input int m, input int i);
      return {8'(m), 8'(i), 48'h0123_4567_89AB};
   endfunction

   task automatic send(input logic [63:0] d, input logic [3:0] nb, input logic last);
      int n = 0;
      bus_if.in_data  = d;
      bus_if.in_bytes = nb;
      bus_if.in_last  = last;
      bus_if.in_valid = 1'b1;
      @(negedge clk);
      while (!bus_if.in_ready && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (!bus_if.in_ready) begin
         checks++;
         failures++;
         $display("FAIL send_timeout in_ready=0 required=1");
      end else begin
         @(posedge clk);
         #1;
      end
      bus_if.in_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(posedge clk);
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL %s_drain pending=%0d required=0", name, exp_q.size());
         exp_q.delete();
      end
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_outputs(input string name);
      chk1({name, "_in_ready"},    64'(bus_if.in_ready),    64'd0);
      chk1({name, "_chunk_valid"}, 64'(bus_if.chunk_valid), 64'd0);
      chk1({name, "_chunk_first"}, 64'(bus_if.chunk_first), 64'd0);
      chk1({name, "_chunk_last"},  64'(bus_if.chunk_last),  64'd0);
      chk1({name, "_err"},         64'(bus_if.err),         64'd0);
      chk_chunk(name, bus_if.chunk, 1024'd0);
   endtask

   // Monitor: every accepted chunk is matched against the scoreboard head.
   always @(negedge clk) begin
      if (!reset && bus_if.chunk_valid && bus_if.chunk_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_chunk word0=%h required=none", bus_if.chunk[1023:960]);
         end else begin
            mon_e = exp_q.pop_front();
            $display("chunk %s first=%0d last=%0d word0=%h word15=%h", mon_e.name,
                     bus_if.chunk_first, bus_if.chunk_last,
                     bus_if.chunk[1023:960], bus_if.chunk[63:0]);
            chk_chunk(mon_e.name, bus_if.chunk, mon_e.data);
            chk1({mon_e.name, "_first"}, 64'(bus_if.chunk_first), 64'(mon_e.first));
            chk1({mon_e.name, "_last"},  64'(bus_if.chunk_last),  64'(mon_e.last));
         end
      end
   end

   // Global time limit.
   initial begin
      #400000;
      $display("FAIL global_timeout time=%0t required=finish", $time);
      $fatal(1, "timeout");
   end

   initial begin
      reset              = 1'b1;
      bus_if.in_data     = '0;
      bus_if.in_bytes    = '0;
      bus_if.in_last     = 1'b0;
      bus_if.in_valid    = 1'b0;
      bus_if.chunk_ready = 1'b1;

      abc_w     = '0;
      abc_w[0]  = 64'h6162638000000000;
      abc_w[15] = 64'h18;

      repeat (3) @(posedge clk);
      #1;
      chk_reset_outputs("reset");
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk1("ready_after_reset", 64'(bus_if.in_ready), 64'd1);

      // "abc" single chunk; valid must rise right after the handshake edge.
      expect_chunk(abc_w, 1'b1, 1'b1, "abc");
      send(64'h6162630000000000, 4'd3, 1'b1);
      chk1("abc_latency_valid", 64'(bus_if.chunk_valid), 64'd1);
      drain("abc");

      // Empty message.
      w = '0;
      w[0] = 64'h8000000000000000;
      expect_chunk(w, 1'b1, 1'b1, "empty");
      send(64'hDEADBEEFDEADBEEF, 4'd0, 1'b1);
      drain("empty");

      // 112 bytes: marker in word 14, length in a trailing chunk.
      w = '0;
      for (int i = 0; i < 14; i++) w[i] = dw(1, i);
      w[14] = 64'h8000000000000000;
      expect_chunk(w, 1'b1, 1'b0, "m112_a");
      w = '0;
      w[15] = 64'h380;
      expect_chunk(w, 1'b0, 1'b1, "m112_b");
      for (int i = 0; i < 14; i++) send(dw(1, i), 4'd8, (i == 13));
      drain("m112");

      // 128 bytes: marker deferred to the trailing chunk.
      w = '0;
      for (int i = 0; i < 16; i++) w[i] = dw(2, i);
      expect_chunk(w, 1'b1, 1'b0, "m128_a");
      w = '0;
      w[0]  = 64'h8000000000000000;
      w[15] = 64'h400;
      expect_chunk(w, 1'b0, 1'b1, "m128_b");
      for (int i = 0; i < 16; i++) send(dw(2, i), 4'd8, (i == 15));
      drain("m128");

      // Backpressure: chunk held stable while chunk_ready is low.
      bus_if.chunk_ready = 1'b0;
      expect_chunk(abc_w, 1'b1, 1'b1, "bp_abc");
      send(64'h6162630000000000, 4'd3, 1'b1);
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         #1;
         chk_chunk("bp_hold", bus_if.chunk, abc_w);
         chk1("bp_hold_in_ready", 64'(bus_if.in_ready), 64'd0);
         chk1("bp_hold_valid",    64'(bus_if.chunk_valid), 64'd1);
      end
      bus_if.chunk_ready = 1'b1;
      @(posedge clk);
      #1;
      chk1("bp_release_valid", 64'(bus_if.chunk_valid), 64'd0);
      drain("bp");

      // Two messages back to back; second restarts first flag and length.
      w = '0;
      for (int i = 0; i < 3; i++) w[i] = dw(3, i);
      w[3]  = 64'h1122800000000000;
      w[15] = 64'hD0;
      expect_chunk(w, 1'b1, 1'b1, "b2b_m1");
      expect_chunk(abc_w, 1'b1, 1'b1, "b2b_m2");
      for (int i = 0; i < 3; i++) send(dw(3, i), 4'd8, 1'b0);
      send(64'h1122334455667788, 4'd2, 1'b1);
      send(64'h6162630000000000, 4'd3, 1'b1);
      drain("b2b");

      // Reset in the middle of a fill discards the partial message.
      for (int i = 0; i < 5; i++) send(dw(4, i), 4'd8, 1'b0);
      reset = 1'b1;
      #2;
      chk_reset_outputs("midfill_reset");
      @(posedge clk);
      #1;
      reset = 1'b0;
      expect_chunk(abc_w, 1'b1, 1'b1, "post_reset_abc");
      send(64'h6162630000000000, 4'd3, 1'b1);
      drain("post_reset");

`ifdef SHA512_PAD_ERR_CHECK_EN
      chk1("err_clear_before", 64'(bus_if.err), 64'd0);
      send(dw(5, 0), 4'd3, 1'b0);
      chk1("err_short_nonlast", 64'(bus_if.err), 64'd1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      chk1("err_cleared_by_reset", 64'(bus_if.err), 64'd0);
`else
      send(dw(5, 0), 4'd8, 1'b0);
      chk1("err_tied_low", 64'(bus_if.err), 64'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sha512_pad.md
Name: sha512_pad

Overview:
- Message-side front end for `sha512_chunk`.
- Accepts a byte stream as 64-bit big-endian words with a valid/ready handshake.
- Assembles 1024-bit chunks and applies SHA-512 padding: a 0x80 byte, zero fill, then a 128-bit big-endian bit length.
- Presents each chunk with first/last flags to the chunk sequencer that drives `sha512_chunk` and chains oH into iH.

Parameters:
- LEN_W, 64, width of the internal byte counter; bit-length field upper (128-LEN_W-3) bits are zero.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- in_data  in  64  message word; byte 0 is in_data[63:56].
- in_bytes  in  4  valid bytes in in_data, left-justified; must be 8 unless in_last; 0..8 on in_last.
- in_last  in  1  final word of message.
- in_valid  in  1  word present.
- in_ready  out  1  block can accept a word.
- chunk  out  1024  padded chunk; word 0 is chunk[1023:960].
- chunk_first  out  1  chunk is first of message (caller loads initial H).
- chunk_last  out  1  chunk is final of message (oH is digest).
- chunk_valid  out  1  chunk is stable and offered.
- chunk_ready  in  1  consumer accepts chunk.
- err  out  1  sticky protocol error (only with optional feature).

Behaviour:
- Reset values: in_ready=0, chunk=0, chunk_valid=0, chunk_first=0, chunk_last=0, err=0. Internal state: word index=0, byte count=0, first flag=1, pend80=0.
- Single chunk buffer; no overlap between fill and emit.
- FSM states: FILL, EMIT, PAD, EMIT_PAD.
  - FILL: in_ready=1.
    - A handshake (in_valid & in_ready) writes the left in_bytes bytes of in_data into word[idx], zeroes the rest of that word, idx++, and count += in_bytes.
    - Not last and idx becomes 16 -> EMIT with last=0.
    - in_last at byte position p = idx*8 + in_bytes:
      - p <= 111: byte p = 0x80, bytes p+1..111 = 0, bytes 112..127 = count*8; -> EMIT with last=1.
      - 112 <= p <= 127: byte p = 0x80, rest zero; -> EMIT with last=0, then PAD.
      - p = 128: no 0x80 in this chunk; set pend80; -> EMIT with last=0, then PAD.
  - EMIT / EMIT_PAD: chunk_valid=1, in_ready=0, chunk held stable.
    - On chunk_ready: clear buffer, clear first flag.
    - EMIT with last=1 -> FILL, with first flag=1 and count=0.
    - EMIT after a 112..128 end -> PAD.
    - EMIT otherwise -> FILL with idx=0.
  - PAD: one cycle; builds an all-zero chunk with word15 = count*8, plus byte 0 = 0x80 if pend80; -> EMIT_PAD with last=1.
  - EMIT_PAD on chunk_ready -> FILL with full message reset.
- Latency: chunk_valid rises the cycle after the completing input handshake; 2 cycles to the PAD chunk after the first chunk is accepted.
- Empty message: in_last with in_bytes=0 at idx=0 yields a single chunk with word0=0x8000000000000000 and all other words 0.
- Length: count wraps modulo 2^LEN_W; the length field is {zeros, count, 3'b000}.
- chunk_first=1 on the first chunk of every message; both flags are 1 for a single-chunk message.
- chunk_valid stays asserted until accepted; chunk_ready while chunk_valid=0 is ignored.
- Reset asserted mid-chunk or mid-emit discards the partial message immediately, with no output glitch beyond the reset values.

Optional Feature:
- Macro `SHA512_PAD_ERR_CHECK_EN`.
- Defined: err is set (sticky until reset) on any of:
  - in_bytes!=8 on a non-last word;
  - in_bytes>8;
  - count wrap.
  - The offending word is still accepted, with in_bytes clamped to 8.
- Undefined: err is tied 0, no checks are performed, and out-of-range in_bytes behaviour is undefined.

Decomposition:
- Package sha512_pkg:
  - CHUNK_BITS=1024, WORD_BITS=64, WORDS_PER_CHUNK=16, LEN_FIELD_BYTES=16, PAD_BYTE=8'h80;
  - state enum typedef;
  - typedef `logic [0:15][63:0] chunk_words_t`.
- One sub-module, sha512_pad_word: combinational mask/insert of 0x80 into a word given in_bytes; shared by the FILL and PAD paths.

Test Plan:
- "abc": in_data=0x6162630000000000, in_bytes=3, last -> one chunk:
  - word0=0x6162638000000000, words1..14=0, word15=0x18;
  - first=1, last=1.
- Empty: in_bytes=0, last -> word0=0x8000000000000000, word15=0, first=last=1.
- 112 bytes (14 full words, the 14th with last) -> chunk A: words0..13 data, word14=0x8000000000000000, word15=0, first=1, last=0. Then chunk B: all zero except word15=0x380, first=0, last=1.
- 128 bytes (16 full words, last on the 16th) -> chunk A: pure data. Then chunk B: word0=0x8000000000000000, word15=0x400, last=1.
- Backpressure: hold chunk_ready=0 for 10 cycles -> chunk stable, in_ready=0, chunk_valid=1; releasing it accepts in one cycle. Follow with a 2-message back-to-back run: second message shows first=1 and length restarted.
- Reset mid-fill after 5 words -> all outputs return to reset values; a following "abc" gives the exact chunk above. With `SHA512_PAD_ERR_CHECK_EN`, a non-last word with in_bytes=3 sets err=1.
